// File: rtl/factorial_cu_pkg.sv
// factorial_cu_pkg: state encodings shared by the factorial control unit and its top wrapper
package factorial_cu_pkg;
  localparam int CU_STATE_W = 3;
  typedef enum logic [CU_STATE_W-1:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    CHECK = 3'd2,
    MULT  = 3'd3,
    DONE  = 3'd4,
    ERR   = 3'd5
  } state_e;
endpackage

// File: rtl/factorial_cu.sv
// factorial_cu: Moore control FSM sequencing load, compare and multiply-decrement for the factorial datapath
module factorial_cu
  import factorial_cu_pkg::*;
#(
  parameter int STATE_W = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               go,
  input  logic               x_GT_1,
  input  logic               x_GT_12,
  output logic               ld_CNT,
  output logic               en_CNT,
  output logic               ld_REG,
  output logic               sel_MUX,
  output logic               OE_BUF,
  output logic               done,
  output logic               err,
  output logic               busy,
  output logic [STATE_W-1:0] cs
);
  state_e state_q, state_d;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  // Outputs decode the state register only; encodings 6/7 fall to the default and recover to IDLE.
  always_comb begin
    state_d = IDLE;
    ld_CNT  = 1'b0;
    en_CNT  = 1'b0;
    ld_REG  = 1'b0;
    sel_MUX = 1'b0;
    OE_BUF  = 1'b0;
    done    = 1'b0;
    err     = 1'b0;
    busy    = 1'b0;
    case (state_q)
      IDLE:  state_d = go ? LOAD : IDLE;
      LOAD: begin
        ld_CNT  = 1'b1;
        ld_REG  = 1'b1;
        busy    = 1'b1;
        state_d = CHECK;
      end
      CHECK: begin
        busy    = 1'b1;
        state_d = x_GT_12 ? ERR : x_GT_1 ? MULT : DONE;
      end
      MULT: begin
        sel_MUX = 1'b1;
        ld_REG  = 1'b1;
        en_CNT  = 1'b1;
        busy    = 1'b1;
        state_d = CHECK;
      end
      DONE: begin
        OE_BUF  = 1'b1;
        done    = 1'b1;
        state_d = go ? DONE : IDLE;
      end
      ERR: begin
        err     = 1'b1;
        state_d = go ? ERR : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  assign cs = STATE_W'(state_q);
endmodule
